// File: rtl/rgb_fade_ctrl.sv
// ---------------------------------------------------------------------------
// rgb_fade_ctrl
// Supplies the three 8-bit duty values for the R/G/B PWM drivers. A target
// colour is taken over a valid/ready handshake and is either applied at once
// (jump) or approached linearly, at most STEP per channel per fade tick.
//
// Parameters
//   TICK_DIV : clock cycles per fade tick (>= 1)
//   STEP     : largest duty change per channel per tick (1..255)
//
// Ports
//   clk                  system clock, rising edge
//   rst_n                asynchronous active-low reset
//   tgt_valid/tgt_ready  target handshake; ready only while idle
//   tgt_r/g/b            target duties
//   fade_en              sampled at accept: 1 = ramp, 0 = jump
//   duty_r/g/b           registered duties to the PWM drivers
//   busy                 registered, high while ramping
//   done                 registered one-cycle pulse when the target is reached
// ---------------------------------------------------------------------------
module rgb_fade_ctrl #(
  parameter int TICK_DIV = 1000,
  parameter int STEP     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tgt_valid,
  output logic       tgt_ready,
  input  logic [7:0] tgt_r,
  input  logic [7:0] tgt_g,
  input  logic [7:0] tgt_b,
  input  logic       fade_en,
  output logic [7:0] duty_r,
  output logic [7:0] duty_g,
  output logic [7:0] duty_b,
  output logic       busy,
  output logic       done
);

  localparam int              CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [7:0]       STEP_V    = 8'(STEP);

  typedef enum logic {
    IDLE = 1'b0,
    FADE = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]       r_tgt_r, r_tgt_g, r_tgt_b;
  logic [7:0]       w_tgt_r_nxt, w_tgt_g_nxt, w_tgt_b_nxt;
  logic [7:0]       r_duty_r, r_duty_g, r_duty_b;
  logic [7:0]       w_duty_r_nxt, w_duty_g_nxt, w_duty_b_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;

  logic             w_tick;
  logic [7:0]       w_step_r, w_step_g, w_step_b;

  // One bounded step of cur towards tgt. The difference is taken at 9 bits
  // signed so neither direction can wrap, and a remaining distance of at most
  // STEP lands exactly on the target instead of overshooting.
  function automatic logic [7:0] f_step(input logic [7:0] cur, input logic [7:0] tgt);
    logic signed [8:0] diff;
    logic [7:0]        mag;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag  = diff[8] ? 8'(-diff) : diff[7:0];
    if (diff == 9'sd0)
      f_step = cur;
    else if (mag <= STEP_V)
      f_step = tgt;
    else if (diff[8])
      f_step = cur - STEP_V;
    else
      f_step = cur + STEP_V;
  endfunction

  assign w_tick   = (r_cnt == TICK_LAST);
  assign w_step_r = f_step(r_duty_r, r_tgt_r);
  assign w_step_g = f_step(r_duty_g, r_tgt_g);
  assign w_step_b = f_step(r_duty_b, r_tgt_b);

  assign tgt_ready = (r_state == IDLE);
  assign duty_r    = r_duty_r;
  assign duty_g    = r_duty_g;
  assign duty_b    = r_duty_b;
  assign busy      = r_busy;
  assign done      = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_tgt_r  <= '0;
      r_tgt_g  <= '0;
      r_tgt_b  <= '0;
      r_duty_r <= '0;
      r_duty_g <= '0;
      r_duty_b <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_tgt_r  <= w_tgt_r_nxt;
      r_tgt_g  <= w_tgt_g_nxt;
      r_tgt_b  <= w_tgt_b_nxt;
      r_duty_r <= w_duty_r_nxt;
      r_duty_g <= w_duty_g_nxt;
      r_duty_b <= w_duty_b_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_tgt_r_nxt  = r_tgt_r;
    w_tgt_g_nxt  = r_tgt_g;
    w_tgt_b_nxt  = r_tgt_b;
    w_duty_r_nxt = r_duty_r;
    w_duty_g_nxt = r_duty_g;
    w_duty_b_nxt = r_duty_b;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;

    case (r_state)
      IDLE: begin
        if (tgt_valid) begin
          w_tgt_r_nxt = tgt_r;
          w_tgt_g_nxt = tgt_g;
          w_tgt_b_nxt = tgt_b;
          if (!fade_en) begin
            w_duty_r_nxt = tgt_r;
            w_duty_g_nxt = tgt_g;
            w_duty_b_nxt = tgt_b;
            w_done_nxt   = 1'b1;
          end else if ({tgt_r, tgt_g, tgt_b} == {r_duty_r, r_duty_g, r_duty_b}) begin
            // Nothing to ramp: acknowledge without entering FADE.
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = FADE;
            w_busy_nxt  = 1'b1;
            w_cnt_nxt   = '0;
          end
        end
      end

      FADE: begin
        if (w_tick) begin
          w_cnt_nxt    = '0;
          w_duty_r_nxt = w_step_r;
          w_duty_g_nxt = w_step_g;
          w_duty_b_nxt = w_step_b;
          // Finish on the same edge that lands the last channel on target.
          if ({w_step_r, w_step_g, w_step_b} == {r_tgt_r, r_tgt_g, r_tgt_b}) begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule
